game_frame_controller: RTL and testbench
========================================

Name: game_frame_controller

Overview:
Per-frame sequencer for the two-player paddle game. It replaces free-running per-frame logic with one synchronous FSM clocked by the pixel clock. The FSM detects frame boundaries, moves and clamps both paddles, starts the ball-physics processor once per frame through a start/done handshake, and latches ball position, round winner and scores. It sits between the VGA timing generator, the player buttons and the processor wrapper. All outputs feed the paddle/ball/segment bound logic and the 7-segment decoder.

Parameters:
STEP, 1, paddle pixels moved per frame per pressed button
SERVE_FRAMES, 60, frames ball is held at init position before play
HOLD_FRAMES, 120, frames winner is displayed before next serve
P1_XMIN, 26, P1_XMAX, 270: p1 x clamp range (inclusive)
P2_XMIN, 370, P2_XMAX, 614: p2 x clamp range (inclusive)
YMIN, 34, YMAX, 446: paddle y clamp range (inclusive, both players)
BALL_XINIT, 320, BALL_YINIT, 240: serve position

Ports:
clk  in  1  25 MHz pixel clock (same clock as the timing generator)
reset  in  1  asynchronous, active-low reset
screenEnd  in  1  high between frames, synchronous to clk
p1_up, p1_down, p1_left, p1_right  in  1 each  player 1 buttons, already synchronised
p2_up, p2_down, p2_left, p2_right  in  1 each  player 2 buttons
proc_done  in  1  processor finished the frame's ball update
proc_ball_x  in  10  ball x from processor
proc_ball_y  in  9  ball y from processor
proc_winner  in  3  0 = no score, 1 = p1 scored, 2 = p2 scored, other = ignored
proc_start  out  1  one-cycle pulse: compute next ball position
p1_xRef, p2_xRef  out  10  paddle centre x
p1_yRef, p2_yRef  out  9  paddle centre y
ball_xRef  out  10  ball centre x
ball_yRef  out  9  ball centre y
winner  out  3  last round winner, to segment decoder
p1_score, p2_score  out  4  saturating scores
overrun  out  1  sticky: processor missed a frame
state  out  2  FSM state, for debug

Behaviour:
- Reset (reset=0, async): state=SERVE; p1=(80,240); p2=(560,240); ball=(BALL_XINIT,BALL_YINIT); proc_start=0; winner=0; scores=0; overrun=0; frame counter=0.
- frame_tick: registered rising-edge detect of screenEnd, one cycle wide, one cycle after the rise. A screenEnd held high for many cycles still yields exactly one tick.
- Paddle update, every frame_tick in all states except SCORED:
  - up XOR down changes y by ∓STEP; left XOR right changes x by ∓STEP. Both opposing buttons pressed gives no move.
  - The result is clamped to its range. Compute in 11 bits so there is no wrap at 0. At the limit, the paddle stays at the limit; it is never reset to the opposite bound.
- States:
  - SERVE (0): ball held at init. Counter increments on each frame_tick. When the counter reaches SERVE_FRAMES, clear it and go to PLAY.
  - PLAY (1):
    - On frame_tick, if no request is outstanding: pulse proc_start and set busy.
    - While busy, the first cycle with proc_done=1 latches proc_ball_x/y into ball_xRef/yRef and clears busy.
    - If proc_winner is 1 or 2 at that cycle: winner<=proc_winner, increment that player's score (saturate at 9), go to SCORED.
    - proc_done while not busy is ignored.
  - SCORED (2): paddles and ball frozen. Counter counts frame_ticks up to HOLD_FRAMES, then goes to SERVE with ball reset to init. winner persists until the next score.
- Overrun: a frame_tick while busy sets overrun (sticky until reset). No new proc_start is issued; the ball holds its position; busy stays set.
- proc_done and frame_tick in the same cycle: the done is consumed first, and a new proc_start is issued on that tick.
- Outputs are registered. Ball/paddle values change only on frame_tick or done cycles, so they are stable across the visible frame.
- Reset mid-handshake clears busy. A late proc_done is then ignored.

Test Plan:
- Release reset, toggle screenEnd with 60 frame pulses -> proc_start stays 0 and ball=(320,240). The 61st tick gives state=PLAY and a proc_start pulse one cycle after the tick.
- p1_left held for 100 frames from x=80 -> x=26 after 54 frames, then stays 26. p1_left+p1_right together -> x unchanged.
- p2_down held from y=240 for 300 frames -> y saturates at 446. p2_up held from 34 -> stays 34.
- PLAY, proc_done with ball (400,100), winner=0, two cycles after start -> ball_xRef=400, ball_yRef=100 on the next cycle.
- proc_done with winner=2 -> p2_score=1, winner=2, state=SCORED. Paddles frozen for 120 ticks, then state=SERVE and ball=(320,240). Ten p2 wins -> p2_score=9.
- No proc_done before the next frame_tick -> overrun=1, no second proc_start. A later done latches the ball and normal pulses resume on the next tick.

Source files
------------

// File: rtl/game_frame_controller.sv
// Per-frame sequencer for the paddle game: frame-tick detect, paddle move/clamp,
// ball-processor start/done handshake, scoring and serve/hold timing.
//   state  | meaning
//   SERVE  | ball held at serve position, counting frames before play
//   PLAY   | one processor request per frame, ball follows processor results
//   SCORED | paddles and ball frozen while the winner is displayed
module game_frame_controller #(
    parameter int STEP         = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int HOLD_FRAMES  = 120,
    parameter int P1_XMIN      = 26,
    parameter int P1_XMAX      = 270,
    parameter int P2_XMIN      = 370,
    parameter int P2_XMAX      = 614,
    parameter int YMIN         = 34,
    parameter int YMAX         = 446,
    parameter int BALL_XINIT   = 320,
    parameter int BALL_YINIT   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       screenEnd,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       p2_left,
    input  logic       p2_right,
    input  logic       proc_done,
    input  logic [9:0] proc_ball_x,
    input  logic [8:0] proc_ball_y,
    input  logic [2:0] proc_winner,
    output logic       proc_start,
    output logic [9:0] p1_xRef,
    output logic [9:0] p2_xRef,
    output logic [8:0] p1_yRef,
    output logic [8:0] p2_yRef,
    output logic [9:0] ball_xRef,
    output logic [8:0] ball_yRef,
    output logic [2:0] winner,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       overrun,
    output logic [1:0] state
);

    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, SCORED = 2'd2} state_t;

    localparam logic [10:0] STEP_W     = 11'(STEP);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [9:0]  BALL_X0    = 10'(BALL_XINIT);
    localparam logic [8:0]  BALL_Y0    = 9'(BALL_YINIT);

    // 11-bit arithmetic so a decrement near zero cannot wrap past the lower bound
    function automatic logic [10:0] step_clamp(input logic [10:0] v, input logic inc,
                                               input logic dec, input logic [10:0] lo,
                                               input logic [10:0] hi);
        logic [10:0] r;
        r = v;
        if (inc && !dec)
            r = (v + STEP_W > hi) ? hi : v + STEP_W;
        else if (dec && !inc)
            r = (v < lo + STEP_W) ? lo : v - STEP_W;
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       screen_end_q, frame_tick_q, frame_tick_d;
    logic       busy_q, busy_d, proc_start_q, proc_start_d, overrun_q, overrun_d;
    logic [9:0] p1_x_q, p1_x_d, p2_x_q, p2_x_d, ball_x_q, ball_x_d;
    logic [8:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d, ball_y_q, ball_y_d;
    logic [2:0] winner_q, winner_d;
    logic [3:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic       done_acc, scoring;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_tick_d = screenEnd & ~screen_end_q;
        busy_d       = busy_q;
        proc_start_d = 1'b0;
        overrun_d    = overrun_q;
        p1_x_d       = p1_x_q;
        p1_y_d       = p1_y_q;
        p2_x_d       = p2_x_q;
        p2_y_d       = p2_y_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        winner_d     = winner_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        done_acc     = busy_q & proc_done;
        scoring      = done_acc && (proc_winner == 3'd1 || proc_winner == 3'd2);

        if (frame_tick_q && state_q != SCORED) begin
            p1_x_d = 10'(step_clamp({1'b0, p1_x_q}, p1_right, p1_left, 11'(P1_XMIN), 11'(P1_XMAX)));
            p1_y_d = 9'(step_clamp({2'b0, p1_y_q}, p1_down, p1_up, 11'(YMIN), 11'(YMAX)));
            p2_x_d = 10'(step_clamp({1'b0, p2_x_q}, p2_right, p2_left, 11'(P2_XMIN), 11'(P2_XMAX)));
            p2_y_d = 9'(step_clamp({2'b0, p2_y_q}, p2_down, p2_up, 11'(YMIN), 11'(YMAX)));
        end

        case (state_q)
            SERVE: begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                if (frame_tick_q) begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                if (done_acc) begin
                    ball_x_d = proc_ball_x;
                    ball_y_d = proc_ball_y;
                    busy_d   = 1'b0;
                end
                if (scoring) begin
                    winner_d = proc_winner;
                    if (proc_winner == 3'd1)
                        p1_score_d = (p1_score_q == 4'd9) ? 4'd9 : p1_score_q + 4'd1;
                    else
                        p2_score_d = (p2_score_q == 4'd9) ? 4'd9 : p2_score_q + 4'd1;
                    cnt_d   = '0;
                    state_d = SCORED;
                end
                // a done arriving with the tick frees the processor for this same tick
                if (frame_tick_q && !scoring) begin
                    if (!busy_q || done_acc) begin
                        proc_start_d = 1'b1;
                        busy_d       = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            SCORED: begin
                if (frame_tick_q) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d    = '0;
                        state_d  = SERVE;
                        ball_x_d = BALL_X0;
                        ball_y_d = BALL_Y0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SERVE;
            cnt_q        <= '0;
            screen_end_q <= 1'b0;
            frame_tick_q <= 1'b0;
            busy_q       <= 1'b0;
            proc_start_q <= 1'b0;
            overrun_q    <= 1'b0;
            p1_x_q       <= 10'd80;
            p1_y_q       <= 9'd240;
            p2_x_q       <= 10'd560;
            p2_y_q       <= 9'd240;
            ball_x_q     <= BALL_X0;
            ball_y_q     <= BALL_Y0;
            winner_q     <= '0;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            screen_end_q <= screenEnd;
            frame_tick_q <= frame_tick_d;
            busy_q       <= busy_d;
            proc_start_q <= proc_start_d;
            overrun_q    <= overrun_d;
            p1_x_q       <= p1_x_d;
            p1_y_q       <= p1_y_d;
            p2_x_q       <= p2_x_d;
            p2_y_q       <= p2_y_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            winner_q     <= winner_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
        end
    end

    assign proc_start = proc_start_q;
    assign p1_xRef    = p1_x_q;
    assign p1_yRef    = p1_y_q;
    assign p2_xRef    = p2_x_q;
    assign p2_yRef    = p2_y_q;
    assign ball_xRef  = ball_x_q;
    assign ball_yRef  = ball_y_q;
    assign winner     = winner_q;
    assign p1_score   = p1_score_q;
    assign p2_score   = p2_score_q;
    assign overrun    = overrun_q;
    assign state      = state_q;

endmodule

// File: tb/tb_game_frame_controller.sv
// Bench for game_frame_controller: scenario tasks against a frame-level game model
// with a reactive processor stand-in that answers proc_start after a random latency.
module tb_game_frame_controller;

    localparam int STEP = 1, SERVE_FRAMES = 60, HOLD_FRAMES = 120;
    localparam int P1_XMIN = 26, P1_XMAX = 270, P2_XMIN = 370, P2_XMAX = 614;
    localparam int YMIN = 34, YMAX = 446;

    logic       clk = 1'b0;
    logic       reset, screenEnd;
    logic       p1_up, p1_down, p1_left, p1_right, p2_up, p2_down, p2_left, p2_right;
    logic       proc_done;
    logic [9:0] proc_ball_x;
    logic [8:0] proc_ball_y;
    logic [2:0] proc_winner;
    logic       proc_start, overrun;
    logic [9:0] p1_xRef, p2_xRef, ball_xRef;
    logic [8:0] p1_yRef, p2_yRef, ball_yRef;
    logic [2:0] winner;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state;

    always #20 clk = ~clk;

    game_frame_controller dut (
        .clk(clk), .reset(reset), .screenEnd(screenEnd),
        .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
        .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
        .proc_done(proc_done), .proc_ball_x(proc_ball_x), .proc_ball_y(proc_ball_y),
        .proc_winner(proc_winner), .proc_start(proc_start),
        .p1_xRef(p1_xRef), .p2_xRef(p2_xRef), .p1_yRef(p1_yRef), .p2_yRef(p2_yRef),
        .ball_xRef(ball_xRef), .ball_yRef(ball_yRef), .winner(winner),
        .p1_score(p1_score), .p2_score(p2_score), .overrun(overrun), .state(state)
    );

    int checks = 0, errors = 0;
    int start_seen = 0, start_bad = 0, lat = 0;
    bit auto_proc = 0;

    // game model: mode 0 serve, 1 play, 2 scored
    int m_mode, m_cnt, m_busy, m_start, m_overrun, m_tick_next, m_se_prev;
    int m_p1x, m_p1y, m_p2x, m_p2y, m_bx, m_by, m_winner, m_s1, m_s2;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_busy = 0; m_start = 0; m_overrun = 0;
        m_tick_next = 0; m_se_prev = 0;
        m_p1x = 80; m_p1y = 240; m_p2x = 560; m_p2y = 240; m_bx = 320; m_by = 240;
        m_winner = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_edge();
        int t;
        bit scored;
        t = m_tick_next;
        m_tick_next = (screenEnd && !m_se_prev) ? 1 : 0;
        m_se_prev = int'(screenEnd);
        m_start = 0;
        scored = 0;
        if (t == 1 && m_mode != 2) begin
            m_p1x = clampi(m_p1x + STEP * (int'(p1_right) - int'(p1_left)), P1_XMIN, P1_XMAX);
            m_p1y = clampi(m_p1y + STEP * (int'(p1_down) - int'(p1_up)), YMIN, YMAX);
            m_p2x = clampi(m_p2x + STEP * (int'(p2_right) - int'(p2_left)), P2_XMIN, P2_XMAX);
            m_p2y = clampi(m_p2y + STEP * (int'(p2_down) - int'(p2_up)), YMIN, YMAX);
        end
        if (m_mode == 0) begin
            if (t == 1) begin
                m_cnt++;
                if (m_cnt == SERVE_FRAMES) begin m_cnt = 0; m_mode = 1; end
            end
        end else if (m_mode == 1) begin
            if (m_busy == 1 && proc_done) begin
                m_bx = int'(proc_ball_x); m_by = int'(proc_ball_y); m_busy = 0;
                if (proc_winner == 3'd1 || proc_winner == 3'd2) begin
                    m_winner = int'(proc_winner);
                    if (proc_winner == 3'd1) m_s1 = (m_s1 >= 9) ? 9 : m_s1 + 1;
                    else                     m_s2 = (m_s2 >= 9) ? 9 : m_s2 + 1;
                    m_mode = 2; m_cnt = 0; scored = 1;
                end
            end
            if (t == 1 && !scored) begin
                if (m_busy == 0) begin m_start = 1; m_busy = 1; end
                else m_overrun = 1;
            end
        end else begin
            if (t == 1) begin
                m_cnt++;
                if (m_cnt == HOLD_FRAMES) begin m_cnt = 0; m_mode = 0; m_bx = 320; m_by = 240; end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        if (proc_start === 1'b1) start_seen++;
        if (proc_start !== 1'(m_start)) start_bad++;
        if (auto_proc) begin
            proc_done = 1'b0;
            if (proc_start === 1'b1) lat = $urandom_range(1, 3);
            else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    proc_done   = 1'b1;
                    proc_ball_x = 10'($urandom_range(0, 639));
                    proc_ball_y = 9'($urandom_range(0, 479));
                    proc_winner = 3'd0;
                end
            end
        end
    endtask

    task automatic frame(input int nh);
        screenEnd = 1'b1;
        repeat (nh) clk_step();
        screenEnd = 1'b0;
        repeat (6) clk_step();
    endtask

    task automatic set_buttons(input logic [7:0] b);
        {p1_up, p1_down, p1_left, p1_right, p2_up, p2_down, p2_left, p2_right} = b;
    endtask

    task automatic manual_done(input int x, input int y, input int w);
        proc_done = 1'b1; proc_ball_x = 10'(x); proc_ball_y = 9'(y); proc_winner = 3'(w);
        clk_step();
        proc_done = 1'b0; proc_winner = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        model_reset();
        checks++;
        if ({state, proc_start, overrun, winner, p1_score, p2_score} !== 16'd0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d start=%0b ovr=%0b win=%0d s1=%0d s2=%0d expected all 0",
                     state, proc_start, overrun, winner, p1_score, p2_score);
        end
        checks++;
        if (p1_xRef !== 10'd80 || p1_yRef !== 9'd240 || p2_xRef !== 10'd560 || p2_yRef !== 9'd240) begin
            errors++;
            $display("FAIL reset_paddles: got (%0d,%0d) (%0d,%0d) expected (80,240) (560,240)",
                     p1_xRef, p1_yRef, p2_xRef, p2_yRef);
        end
        checks++;
        if (ball_xRef !== 10'd320 || ball_yRef !== 9'd240) begin
            errors++;
            $display("FAIL reset_ball: got (%0d,%0d) expected (320,240)", ball_xRef, ball_yRef);
        end
        reset = 1'b1;
    endtask

    task automatic test_serve_and_handshake();
        repeat (SERVE_FRAMES) frame(2);
        checks++;
        if (start_seen != 0 || ball_xRef !== 10'd320 || ball_yRef !== 9'd240) begin
            errors++;
            $display("FAIL serve_hold: starts=%0d ball=(%0d,%0d) expected 0 starts ball (320,240)",
                     start_seen, ball_xRef, ball_yRef);
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL serve_to_play: state=%0d expected 1", state);
        end
        screenEnd = 1'b1;
        clk_step();
        checks++;
        if (proc_start !== 1'b0) begin
            errors++;
            $display("FAIL start_early: proc_start=%0b expected 0 on tick cycle", proc_start);
        end
        clk_step();
        checks++;
        if (proc_start !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: proc_start=%0b expected 1 one cycle after tick", proc_start);
        end
        clk_step();
        manual_done(400, 100, 0);
        checks++;
        if (ball_xRef !== 10'd400 || ball_yRef !== 9'd100) begin
            errors++;
            $display("FAIL ball_latch: got (%0d,%0d) expected (400,100)", ball_xRef, ball_yRef);
        end
        repeat (8) clk_step();
        screenEnd = 1'b0;
        repeat (6) clk_step();
        checks++;
        if (start_seen != 1 || start_bad != 0) begin
            errors++;
            $display("FAIL held_screen_end: starts=%0d misplaced=%0d expected 1 and 0", start_seen, start_bad);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        frame(2);
        s0 = start_seen;
        screenEnd = 1'b1;
        clk_step();
        proc_done = 1'b1; proc_ball_x = 10'd200; proc_ball_y = 9'd300; proc_winner = 3'd0;
        clk_step();
        proc_done = 1'b0;
        checks++;
        if (proc_start !== 1'b1 || ball_xRef !== 10'd200 || ball_yRef !== 9'd300 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL done_with_tick: start=%0b ball=(%0d,%0d) ovr=%0b expected 1 (200,300) 0",
                     proc_start, ball_xRef, ball_yRef, overrun);
        end
        manual_done(210, 310, 0);
        screenEnd = 1'b0;
        repeat (6) clk_step();
        checks++;
        if (start_seen != s0 + 1 || start_bad != 0) begin
            errors++;
            $display("FAIL b2b_starts: starts=%0d misplaced=%0d expected %0d and 0", start_seen, start_bad, s0 + 1);
        end
    endtask

    task automatic test_paddle_p1();
        auto_proc = 1; lat = 0;
        set_buttons(8'b0010_0000);
        for (int i = 1; i <= 100; i++) begin
            frame(2);
            if (i == 53 || i == 54 || i == 100) begin
                checks++;
                if (p1_xRef !== 10'(m_p1x) || m_p1x != ((i == 53) ? 27 : 26)) begin
                    errors++;
                    $display("FAIL p1_left_clamp frame %0d: got %0d model %0d", i, p1_xRef, m_p1x);
                end
            end
        end
        set_buttons(8'b0011_0000);
        repeat (10) frame(2);
        checks++;
        if (p1_xRef !== 10'd26) begin
            errors++;
            $display("FAIL p1_both_pressed: got %0d expected 26", p1_xRef);
        end
        set_buttons(8'b0001_0000);
        repeat (5) frame(2);
        checks++;
        if (p1_xRef !== 10'd31 || p1_yRef !== 9'd240) begin
            errors++;
            $display("FAIL p1_right: got (%0d,%0d) expected (31,240)", p1_xRef, p1_yRef);
        end
        set_buttons(8'd0);
    endtask

    task automatic test_paddle_p2();
        set_buttons(8'b0000_0100);
        repeat (300) frame(2);
        checks++;
        if (p2_yRef !== 9'd446) begin
            errors++;
            $display("FAIL p2_down_clamp: got %0d expected 446", p2_yRef);
        end
        set_buttons(8'b0000_1000);
        repeat (420) frame(2);
        checks++;
        if (p2_yRef !== 9'd34 || p2_xRef !== 10'd560) begin
            errors++;
            $display("FAIL p2_up_clamp: got (%0d,%0d) expected (560,34)", p2_xRef, p2_yRef);
        end
        set_buttons(8'd0);
    endtask

    task automatic test_random_play();
        for (int i = 0; i < 200; i++) begin
            set_buttons(8'($urandom));
            frame($urandom_range(1, 4));
            checks++;
            if (p1_xRef !== 10'(m_p1x) || p1_yRef !== 9'(m_p1y) || p2_xRef !== 10'(m_p2x) ||
                p2_yRef !== 9'(m_p2y) || ball_xRef !== 10'(m_bx) || ball_yRef !== 9'(m_by)) begin
                errors++;
                $display("FAIL random_frame %0d: got p1(%0d,%0d) p2(%0d,%0d) ball(%0d,%0d) expected p1(%0d,%0d) p2(%0d,%0d) ball(%0d,%0d)",
                         i, p1_xRef, p1_yRef, p2_xRef, p2_yRef, ball_xRef, ball_yRef,
                         m_p1x, m_p1y, m_p2x, m_p2y, m_bx, m_by);
            end
        end
        set_buttons(8'd0);
        auto_proc = 0;
        checks++;
        if (overrun !== 1'b0 || start_bad != 0) begin
            errors++;
            $display("FAIL random_handshake: ovr=%0b misplaced=%0d expected 0 and 0", overrun, start_bad);
        end
    endtask

    task automatic test_overrun();
        int s0;
        s0 = start_seen;
        frame(2);
        frame(2);
        checks++;
        if (overrun !== 1'b1 || start_seen != s0 + 1) begin
            errors++;
            $display("FAIL overrun_set: ovr=%0b starts=%0d expected 1 and %0d", overrun, start_seen, s0 + 1);
        end
        manual_done(123, 45, 0);
        checks++;
        if (ball_xRef !== 10'd123 || ball_yRef !== 9'd45) begin
            errors++;
            $display("FAIL late_done: ball=(%0d,%0d) expected (123,45)", ball_xRef, ball_yRef);
        end
        frame(2);
        checks++;
        if (start_seen != s0 + 2 || overrun !== 1'b1 || start_bad != 0) begin
            errors++;
            $display("FAIL overrun_resume: starts=%0d ovr=%0b misplaced=%0d expected %0d 1 0",
                     start_seen, overrun, start_bad, s0 + 2);
        end
        manual_done(130, 50, 0);
    endtask

    task automatic test_scoring();
        int sx1, sy1, sx2, sy2;
        for (int w = 0; w < 10; w++) begin
            if (w > 0) repeat (SERVE_FRAMES) frame(2);
            frame(2);
            manual_done($urandom_range(0, 639), $urandom_range(0, 479), 2);
            checks++;
            if (state !== 2'd2 || winner !== 3'd2 || p2_score !== 4'((w + 1 > 9) ? 9 : w + 1)) begin
                errors++;
                $display("FAIL p2_win %0d: state=%0d win=%0d s2=%0d expected 2 2 %0d",
                         w, state, winner, p2_score, (w + 1 > 9) ? 9 : w + 1);
            end
            if (w == 0) begin
                sx1 = int'(p1_xRef); sy1 = int'(p1_yRef); sx2 = int'(p2_xRef); sy2 = int'(p2_yRef);
                set_buttons(8'b1010_0101);
                repeat (HOLD_FRAMES - 1) frame(2);
                checks++;
                if (state !== 2'd2 || p1_xRef !== 10'(sx1) || p1_yRef !== 9'(sy1) ||
                    p2_xRef !== 10'(sx2) || p2_yRef !== 9'(sy2)) begin
                    errors++;
                    $display("FAIL scored_freeze: state=%0d p1(%0d,%0d) p2(%0d,%0d) expected 2 p1(%0d,%0d) p2(%0d,%0d)",
                             state, p1_xRef, p1_yRef, p2_xRef, p2_yRef, sx1, sy1, sx2, sy2);
                end
                frame(2);
                checks++;
                if (state !== 2'd0 || ball_xRef !== 10'd320 || ball_yRef !== 9'd240 || p1_xRef !== 10'(sx1)) begin
                    errors++;
                    $display("FAIL hold_end: state=%0d ball=(%0d,%0d) p1x=%0d expected 0 (320,240) %0d",
                             state, ball_xRef, ball_yRef, p1_xRef, sx1);
                end
                set_buttons(8'd0);
            end else begin
                repeat (HOLD_FRAMES) frame(2);
            end
        end
        checks++;
        if (p2_score !== 4'd9 || 4'(m_s2) !== p2_score) begin
            errors++;
            $display("FAIL p2_saturate: got %0d expected 9", p2_score);
        end
        repeat (SERVE_FRAMES) frame(2);
        frame(2);
        manual_done(50, 60, 5);
        checks++;
        if (state !== 2'd1 || winner !== 3'd2 || ball_xRef !== 10'd50) begin
            errors++;
            $display("FAIL winner_ignored: state=%0d win=%0d bx=%0d expected 1 2 50", state, winner, ball_xRef);
        end
        frame(2);
        manual_done(60, 70, 1);
        checks++;
        if (p1_score !== 4'd1 || winner !== 3'd1 || state !== 2'd2 || p2_score !== 4'd9) begin
            errors++;
            $display("FAIL p1_win: s1=%0d win=%0d state=%0d s2=%0d expected 1 1 2 9",
                     p1_score, winner, state, p2_score);
        end
    endtask

    task automatic test_reset_mid();
        repeat (HOLD_FRAMES + SERVE_FRAMES) frame(2);
        frame(2);
        reset = 1'b0;
        #5;
        model_reset();
        checks++;
        if (overrun !== 1'b0 || p1_score !== 4'd0 || p2_score !== 4'd0 || state !== 2'd0 || winner !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: ovr=%0b s1=%0d s2=%0d state=%0d win=%0d expected all 0",
                     overrun, p1_score, p2_score, state, winner);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        manual_done(9, 9, 2);
        clk_step();
        checks++;
        if (p2_score !== 4'd0 || state !== 2'd0 || ball_xRef !== 10'd320 || ball_yRef !== 9'd240) begin
            errors++;
            $display("FAIL stale_done: s2=%0d state=%0d ball=(%0d,%0d) expected 0 0 (320,240)",
                     p2_score, state, ball_xRef, ball_yRef);
        end
    endtask

    initial begin
        reset = 1'b0; screenEnd = 1'b0; set_buttons(8'd0);
        proc_done = 1'b0; proc_ball_x = '0; proc_ball_y = '0; proc_winner = '0;
        model_reset();
        test_reset();
        test_serve_and_handshake();
        test_back_to_back();
        test_paddle_p1();
        test_paddle_p2();
        test_random_play();
        test_overrun();
        test_scoring();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

endmodule
